// File: rtl/lut_weight_loader_pkg.sv
// rtl/lut_weight_loader_pkg.sv - shared sizing, FSM encoding and helpers for lut_weight_loader
package lut_weight_loader_pkg;

  localparam int unsigned IN_WIDTH_DEF  = 64;
  localparam int unsigned OUT_WIDTH_DEF = 4096;

  function automatic int unsigned beats_of(input int unsigned in_w, input int unsigned out_w);
    return out_w / in_w;
  endfunction

  // A single-beat word still needs a one-bit counter to keep the ports legal.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned BEATS_DEF = beats_of(IN_WIDTH_DEF, OUT_WIDTH_DEF);
  localparam int unsigned CNT_W_DEF = cnt_width(BEATS_DEF);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_CFGWR = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/lut_weight_loader.sv
// rtl/lut_weight_loader.sv - assembles 64-bit beats into LUT images (write pulse) or held weight words
module lut_weight_loader
  import lut_weight_loader_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_cfg,
  output logic [OUT_WIDTH-1:0] out_word,
  output logic                 cfg_update,
  output logic                 lut_wr_valid,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 lut_loaded
);

  localparam int unsigned BEATS = beats_of(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              mode_q, mode_d;
  logic                              lut_loaded_q, lut_loaded_d;
  logic [BEATS-1:0][IN_WIDTH-1:0]    word_q;
  logic [BEATS-1:0]                  slot_we;
  logic                              beat_wr;
  logic                              word_is_lut;

  // Flush drops the beat even though s_ready is still decoded high.
  assign beat_wr = (state_q == ST_FILL) && s_valid && !flush;

  // On a one-beat word the latched mode is not yet valid, so use s_cfg directly.
  assign word_is_lut = (cnt_q == '0) ? s_cfg : mode_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    lut_loaded_d = lut_loaded_q;
    unique case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          if (cnt_q == '0) begin
            mode_d = s_cfg;
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = word_is_lut ? ST_CFGWR : ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CFGWR: begin
        lut_loaded_d = 1'b1;
        state_d      = ST_FILL;
      end
      ST_HOLD: begin
        if (m_ready) begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    if (flush) begin
      state_d = ST_FILL;
      cnt_d   = '0;
    end
  end

  always_comb begin
    slot_we = '0;
    if (beat_wr) begin
      slot_we[cnt_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      lut_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      lut_loaded_q <= lut_loaded_d;
    end
  end

  // Untouched slots keep stale data from the previous word; only complete words are consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      for (int i = 0; i < int'(BEATS); i++) begin
        if (slot_we[i]) begin
          word_q[i] <= s_data;
        end
      end
    end
  end

  assign out_word     = word_q;
  assign s_ready      = (state_q == ST_FILL);
  assign m_valid      = (state_q == ST_HOLD);
  assign cfg_update   = (state_q == ST_CFGWR);
  assign lut_wr_valid = (state_q == ST_CFGWR);
  assign lut_loaded   = lut_loaded_q;

endmodule

// File: tb/tb_lut_weight_loader.sv
// tb/tb_lut_weight_loader.sv - self-checking bench for lut_weight_loader
`timescale 1ns/1ps
module tb_lut_weight_loader;

  localparam int IW = 64;
  localparam int OW = 4096;
  localparam int NB = OW / IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_cfg = 1'b0;
  logic          m_ready = 1'b1;
  logic [IW-1:0] s_data = '0;
  logic          s_ready, cfg_update, lut_wr_valid, m_valid, lut_loaded;
  logic [OW-1:0] out_word;

  always #5 clk = ~clk;

  lut_weight_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_cfg        (s_cfg),
    .out_word     (out_word),
    .cfg_update   (cfg_update),
    .lut_wr_valid (lut_wr_valid),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .lut_loaded   (lut_loaded)
  );

  typedef struct {
    logic          mode;
    logic [OW-1:0] word;
  } exp_t;

  typedef struct {
    logic cfg0;
    bit   toggle;
    int   pat;
    logic exp_lut;
    int   exp_pulses;
    logic exp_loaded;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   evt_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cfg_pulses = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      int s;
      s = 0;
      for (int i = 0; i < NB; i++) begin
        if (act[i*IW +: IW] !== exp[i*IW +: IW]) begin
          s = i;
          break;
        end
      end
      bad++;
      $display("FAIL %s: slot %0d got %h expected %h", name, s, act[s*IW +: IW], exp[s*IW +: IW]);
    end
  endtask

  // Scoreboard: every completed word must surface exactly once, in order.
  always @(negedge clk) begin
    if (rst_n && mon_en && (cfg_update || (m_valid && m_ready))) begin
      evt_cyc.push_back(cyc);
      if (cfg_update) cfg_pulses++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got cfg=%0b m_valid=%0b expected none", cfg_update, m_valid);
      end else begin
        mon_e = sb.pop_front();
        check("word_mode", {63'd0, cfg_update}, {63'd0, mon_e.mode});
        check("lut_wr_valid", {63'd0, lut_wr_valid}, {63'd0, mon_e.mode});
        check_word("word_data", out_word, mon_e.word);
      end
    end
  end

  function automatic logic [IW-1:0] beat_data(input int pat, input int k);
    logic [3:0] n;
    n = k[3:0];
    if (pat == 0) return {16{n}};
    return {pat[15:0] ^ 16'(k), 16'(k * 37 + 1), 16'(pat * 3), ~16'(k)};
  endfunction

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (!s_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Leaves s_valid high so consecutive calls stream without gaps.
  task automatic send_word(input logic cfg0, input bit toggle, input int pat, input int nbeats);
    logic [OW-1:0] w;
    exp_t          e;
    bit            ok;
    w = '0;
    for (int k = 0; k < nbeats; k++) begin
      s_valid = 1'b1;
      s_data  = beat_data(pat, k);
      s_cfg   = (k == 0) ? cfg0 : (toggle ? logic'(k % 2) ^ cfg0 : cfg0);
      wait_ready(ok);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL s_ready_timeout: got s_ready=0 expected 1 at beat %0d", k);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      w[k*IW +: IW] = beat_data(pat, k);
    end
    if (nbeats == NB) begin
      e.mode = cfg0;
      e.word = w;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t          vecs[4];
  logic [OW-1:0] held;
  int            p0;

  initial begin
    vecs[0] = '{cfg0: 1'b1, toggle: 1'b0, pat: 0,  exp_lut: 1'b1, exp_pulses: 1, exp_loaded: 1'b1};
    vecs[1] = '{cfg0: 1'b0, toggle: 1'b0, pat: 5,  exp_lut: 1'b0, exp_pulses: 0, exp_loaded: 1'b1};
    vecs[2] = '{cfg0: 1'b1, toggle: 1'b1, pat: 9,  exp_lut: 1'b1, exp_pulses: 1, exp_loaded: 1'b1};
    vecs[3] = '{cfg0: 1'b0, toggle: 1'b1, pat: 12, exp_lut: 1'b0, exp_pulses: 0, exp_loaded: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {63'd0, s_ready}, 64'd1);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_cfg_update", {63'd0, cfg_update}, 64'd0);
    check("rst_lut_loaded", {63'd0, lut_loaded}, 64'd0);
    check_word("rst_out_word", out_word, '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      p0 = cfg_pulses;
      m_ready = 1'b1;
      send_word(vecs[v].cfg0, vecs[v].toggle, vecs[v].pat, NB);
      check($sformatf("v%0d_cfg_next", v), {63'd0, cfg_update}, {63'd0, vecs[v].exp_lut});
      check($sformatf("v%0d_mvalid_next", v), {63'd0, m_valid}, {63'd0, !vecs[v].exp_lut});
      check($sformatf("v%0d_s_ready_next", v), {63'd0, s_ready}, 64'd0);
      idle(3);
      check($sformatf("v%0d_pulses", v), 64'(cfg_pulses - p0), 64'(vecs[v].exp_pulses));
      check($sformatf("v%0d_lut_loaded", v), {63'd0, lut_loaded}, {63'd0, vecs[v].exp_loaded});
    end

    // Weight word held under backpressure.
    m_ready = 1'b0;
    send_word(1'b0, 1'b0, 40, NB);
    s_valid = 1'b0;
    held = out_word;
    check_word("bp_held_content", held, sb[0].word);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_m_valid_%0d", c), {63'd0, m_valid}, 64'd1);
      check($sformatf("bp_s_ready_%0d", c), {63'd0, s_ready}, 64'd0);
      check_word($sformatf("bp_stable_%0d", c), out_word, held);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_s_ready", {63'd0, s_ready}, 64'd1);
    check("bp_release_m_valid", {63'd0, m_valid}, 64'd0);

    // Flush after beat 30 with a dropped beat in the flush cycle.
    send_word(1'b0, 1'b0, 50, 31);
    flush  = 1'b1;
    s_data = {IW{1'b1}};
    @(posedge clk); #1;
    flush = 1'b0;
    send_word(1'b0, 1'b0, 51, NB);
    idle(3);
    check("flush_sb_empty", 64'(sb.size()), 64'd0);

    // Flush while holding a weight word.
    m_ready = 1'b0;
    send_word(1'b0, 1'b0, 60, NB);
    idle(2);
    held = out_word;
    check("fh_m_valid_before", {63'd0, m_valid}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fh_m_valid_after", {63'd0, m_valid}, 64'd0);
    check("fh_s_ready_after", {63'd0, s_ready}, 64'd1);
    check_word("fh_word_kept", out_word, held);
    if (sb.size() > 0) void'(sb.pop_front());
    m_ready = 1'b1;
    idle(2);

    // Back-to-back LUT, weight, weight.
    evt_cyc.delete();
    send_word(1'b1, 1'b0, 0, NB);
    send_word(1'b0, 1'b0, 71, NB);
    send_word(1'b0, 1'b0, 72, NB);
    idle(3);
    check("b2b_events", 64'(evt_cyc.size()), 64'd3);
    if (evt_cyc.size() == 3) begin
      check("b2b_period_1", 64'(evt_cyc[1] - evt_cyc[0]), 64'd65);
      check("b2b_period_2", 64'(evt_cyc[2] - evt_cyc[1]), 64'd65);
    end
    check("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-fill.
    send_word(1'b0, 1'b0, 80, 40);
    rst_n = 1'b0;
    #1;
    check("mr_s_ready", {63'd0, s_ready}, 64'd1);
    check("mr_m_valid", {63'd0, m_valid}, 64'd0);
    check("mr_cfg_update", {63'd0, cfg_update}, 64'd0);
    check("mr_lut_wr_valid", {63'd0, lut_wr_valid}, 64'd0);
    check("mr_lut_loaded", {63'd0, lut_loaded}, 64'd0);
    check_word("mr_out_word", out_word, '0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(1'b0, 1'b0, 81, NB);
    idle(3);
    check("mr_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lut_weight_loader.md
# lut_weight_loader

Upstream feeder for `lut_bank`. It accepts a narrow valid/ready stream of 64-bit beats and assembles them into 4096-bit words. Each word is either a LUT configuration image, which is issued as a one-cycle `cfg_update`/`lut_wr_valid` write pulse, or a packed 4-bit weight-index word, which is held on the bus with `m_valid` until the consumer accepts it. The block's `out_word` drives `lut_bank.in_weights` directly.

## Interface
- `IN_WIDTH`, 64: input beat width in bits.
- `OUT_WIDTH`, 4096: assembled word width; must be an exact multiple of `IN_WIDTH`.
- `BEATS`, `OUT_WIDTH/IN_WIDTH` (64): beats per word; derived, never overridden.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous abort; discards any partial or held word.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  `IN_WIDTH`  beat payload.
- `s_cfg`  in  1  word type, sampled on beat 0 only: 1 = LUT image, 0 = weights.
- `out_word`  out  `OUT_WIDTH`  assembly register; connects to `lut_bank.in_weights`.
- `cfg_update`  out  1  LUT write strobe.
- `lut_wr_valid`  out  1  LUT write valid; identical to `cfg_update`.
- `m_valid`  out  1  weight word on `out_word` is valid.
- `m_ready`  in  1  consumer accepts the weight word.
- `lut_loaded`  out  1  at least one LUT image has been written since reset.

## Operation
- FSM states: FILL, CFGWR, HOLD. Reset state is FILL.
- Reset values:
  - `out_word` = 0, beat counter = 0, latched mode = 0.
  - `lut_loaded` = 0, `m_valid` = 0, `cfg_update` = 0, `lut_wr_valid` = 0.
  - `s_ready` = 1, because FILL is the reset state.
- FILL:
  - `s_ready` = 1.
  - Each accepted beat with counter value k is written to `out_word[k*IN_WIDTH +: IN_WIDTH]`; the counter then increments.
  - On beat 0, `s_cfg` is latched as the word mode. `s_cfg` on all later beats is ignored.
  - Accepting beat `BEATS-1` resets the counter to 0 and moves to CFGWR if the latched mode is 1, otherwise to HOLD.
- CFGWR:
  - Lasts exactly one cycle.
  - `cfg_update` = `lut_wr_valid` = 1; `s_ready` = 0.
  - `lut_loaded` is set to 1, visible from the next cycle.
  - Always returns to FILL.
- HOLD:
  - `m_valid` = 1; `s_ready` = 0; `out_word` is stable.
  - Leaves for FILL in the cycle where `m_ready` = 1.
- All control outputs (`s_ready`, `m_valid`, `cfg_update`, `lut_wr_valid`) are decoded from the registered state only. There is no combinational path from any input to any output.
- `flush`:
  - Highest priority.
  - Forces next state = FILL and counter = 0.
  - A beat presented in the same cycle is not stored; `s_ready` still reads as decoded, and the beat counts as consumed-and-dropped.
  - A CFGWR pulse already asserted in that cycle is not retracted.
  - `out_word` contents are not cleared.
  - `lut_loaded` is unaffected.
- `out_word` bits not yet overwritten in a new fill keep their old values. Only the final word content matters.

## Timing
- Last beat accepted at cycle t gives either `cfg_update` high in cycle t+1 only, or `m_valid` high from t+1.
- Minimum period per LUT image is `BEATS`+1 cycles. Minimum period per weight word is `BEATS`+1 cycles when `m_ready` is held at 1.
- In HOLD, `m_valid && m_ready` at cycle t gives `s_ready` = 1 at t+1.
- `lut_bank` captures the LUT image at the clock edge that ends the CFGWR cycle. `out_word` is stable throughout CFGWR.
- Mid-operation reset clears all state immediately, asynchronously. Any partial word is lost.

## Structure
- A shared package holds:
  - the FSM state encoding (FILL = 0, CFGWR = 1, HOLD = 2; 2 bits);
  - `IN_WIDTH`/`OUT_WIDTH` defaults;
  - the `BEATS` derivation;
  - the counter width `$clog2(BEATS)`.
- No sub-module. The beat-slot write decoder lives inline.

## Test plan
- **LUT load.** After reset, send 64 beats with `s_cfg`=1 on beat 0; beat k has data {16{k[3:0]}}.
  - Exactly one `cfg_update`/`lut_wr_valid` pulse, one cycle after the last beat.
  - `lut_loaded` = 1 afterwards.
  - `lut_bank` entry [i][j] reads i.
- **Weight word with backpressure.** Send 64 beats with `s_cfg`=0 and `m_ready`=0 for 5 cycles.
  - `m_valid` is held for all 5 cycles; `out_word` is unchanged; `s_ready` = 0.
  - After `m_ready` = 1, `s_ready` = 1 on the next cycle.
- **Mode latch.** Set `s_cfg`=1 on beat 0 and toggle it on later beats.
  - The word is treated as a LUT image.
- **Flush.** Assert `flush` after beat 30, then send a full weight word.
  - Only that full word appears; beat slot 0 holds the new data.
  - `flush` during HOLD drops `m_valid` on the next cycle.
- **Back-to-back traffic.** Alternate LUT image, weight, weight with continuous `s_valid` and `m_ready`=1.
  - Each word completes in 65 cycles.
  - No beat is lost or duplicated; check this with a scoreboard.
- **Reset mid-fill.** Assert `rst_n` low at beat 40.
  - All outputs take their reset values at once.
  - The next 64 beats form a complete word.
